// File: rtl/cic_integrator_decim.sv
// cic_integrator_decim: N-stage CIC integrator cascade at the PDM bit rate with decimate-by-R output strobe.
// Optional CIC_INT_SYNC_EN adds i_sync for decimation-phase realignment across mic arrays.
`default_nettype none

module cic_integrator_decim #(
  parameter int N  = 3,
  parameter int R  = 64,
  parameter int OW = 19
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic                 i_pdm,
`ifdef CIC_INT_SYNC_EN
  input  logic                 i_sync,
`endif
  output logic signed [OW-1:0] o_data,
  output logic                 o_valid
);

  localparam int            CW     = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(R - 1);

  logic signed [OW-1:0] r_integ [N];
  logic signed [OW-1:0] w_next  [N];
  logic signed [OW-1:0] w_x;
  logic        [CW-1:0] r_cnt;
  logic signed [OW-1:0] r_data;
  logic                 r_valid;
  logic                 w_sync;

  // PDM bit maps to +1 / -1 in OW-bit two's complement
  assign w_x = i_pdm ? OW'(1) : {OW{1'b1}};

`ifdef CIC_INT_SYNC_EN
  assign w_sync = i_sync;
`else
  assign w_sync = 1'b0;
`endif

  // Every stage sums pre-edge values, so the cascade is pipelined one stage per sample
  generate
    for (genvar k = 0; k < N; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign w_next[k] = r_integ[k] + w_x;
      end else begin : g_rest
        assign w_next[k] = r_integ[k] + r_integ[k-1];
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) r_integ[k] <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_valid) begin
        for (int k = 0; k < N; k++) r_integ[k] <= w_next[k];
        // Realignment wins over the strobe; the sync sample is integrated but not counted
        if (w_sync) begin
          r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
          r_cnt   <= '0;
          r_data  <= w_next[N-1];
          r_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_cic_integrator_decim.sv
// Scoreboard bench for cic_integrator_decim: closed-form binomial reference model, randomized and directed stimulus.
`default_nettype none

module tb_cic_integrator_decim;

  localparam int N  = 3;
  localparam int R  = 64;
  localparam int OW = 19;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 i_valid = 1'b0;
  logic                 i_pdm = 1'b0;
  logic                 i_sync = 1'b0;
  logic signed [OW-1:0] o_data;
  logic                 o_valid;

  cic_integrator_decim #(.N(N), .R(R), .OW(OW)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_valid (i_valid),
    .i_pdm   (i_pdm),
`ifdef CIC_INT_SYNC_EN
    .i_sync  (i_sync),
`endif
    .o_data  (o_data),
    .o_valid (o_valid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  longint          hist[$];   // +1/-1 samples since reset
  int              cnt;       // samples counted since last strobe/sync
  logic [OW-1:0]   exp_q[$];

  function automatic longint binom(longint m, int k);
    longint r;
    if (m < k) return 0;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (m - i) / (i + 1);
    return r;
  endfunction

  // Last integrator after n samples = sum_j x_j * C(n-1-j, N-1), reduced mod 2^OW
  function automatic logic [OW-1:0] model();
    longint acc;
    longint n;
    acc = 0;
    n = hist.size();
    for (int j = 0; j < hist.size(); j++) acc += hist[j] * binom(n - 1 - j, N - 1);
    return acc[OW-1:0];
  endfunction

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic send(bit pdm, int gap, bit sync = 1'b0);
    repeat (gap) begin
      @(negedge clock);
      i_valid = 1'b0;
      i_sync  = 1'b0;
    end
    @(negedge clock);
    i_valid = 1'b1;
    i_pdm   = pdm;
    i_sync  = sync;
    hist.push_back(pdm ? 64'sd1 : -64'sd1);
    if (sync) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt == R) begin
        cnt = 0;
        exp_q.push_back(model());
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clock);
      i_valid = 1'b0;
      i_sync  = 1'b0;
    end
  endtask

  task automatic do_reset(string name);
    @(negedge clock);
    i_valid = 1'b0;
    i_sync  = 1'b0;
    #2 reset = 1'b1;
    #1;
    check({name, "_reset_o_data"}, longint'(o_data), 0);
    check({name, "_reset_o_valid"}, longint'(o_valid), 0);
    hist.delete();
    exp_q.delete();
    cnt = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: pops on every strobe, and checks o_data holds between strobes
  logic [OW-1:0] last_data;
  initial begin
    logic [OW-1:0] e;
    last_data = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        last_data = '0;
      end else if (o_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_o_valid: got o_data=%0d with no expected sample queued", o_data);
        end else begin
          e = exp_q.pop_front();
          check("o_data", longint'(o_data), longint'(signed'(e)));
        end
        last_data = o_data;
      end else if (o_data != last_data) begin
        check("o_data_hold", longint'(o_data), longint'(signed'(last_data)));
        last_data = o_data;
      end
    end
  end

  initial begin
    cnt = 0;
    #23 reset = 1'b0;
    check("initial_o_data", longint'(o_data), 0);
    check("initial_o_valid", longint'(o_valid), 0);

    // pdm=1 every cycle, two strobes
    for (int i = 0; i < 2 * R; i++) send(1'b1, 0);
    idle(3);

    // alternating 0,1
    do_reset("alt");
    for (int i = 0; i < R; i++) send(i[0], 0);
    idle(3);

    // pdm=1 on every 4th cycle
    do_reset("gap4");
    for (int i = 0; i < R; i++) send(1'b1, 3);
    idle(10);

    // reset mid-stream after 40 samples
    do_reset("mid_pre");
    for (int i = 0; i < 40; i++) send(1'b1, 0);
    do_reset("mid");
    for (int i = 0; i < R; i++) send(1'b1, 0);
    idle(3);

    // constant 0 -> negative output
    do_reset("neg");
    for (int i = 0; i < R; i++) send(1'b0, 0);
    idle(3);

    // random bits with random gaps, many strobes (exercises wrap)
    do_reset("rand");
    for (int i = 0; i < 10 * R + 17; i++) send(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    idle(5);

`ifdef CIC_INT_SYNC_EN
    // sync on sample 20, then R further samples
    do_reset("sync");
    for (int i = 1; i < 20; i++) send(1'b1, 0);
    send(1'b1, 0, 1'b1);
    for (int i = 0; i < R; i++) send(1'b1, ($urandom_range(0, 4) == 0) ? 1 : 0);
    idle(3);
    check("sync_integ0", longint'(signed'(dut.r_integ[0])), longint'(hist.size()));
`endif

    idle(5);
    check("pending_expected", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
